// File: rtl/quad_gen.sv
// -----------------------------------------------------------------------------
// quad_gen
//   Quadrature encoder signal generator. Steps a two-phase A/B Gray-code pair
//   one edge at a time toward a commanded signed target position, with one
//   edge every P clock cycles. P is step_period clamped to MIN_STEP_PERIOD.
//
//   Forward sequence (decoder counts up): AB = 00 -> 10 -> 11 -> 01 -> 00.
//   The emitted phases always encode position mod 4:
//     0 -> 00, 1 -> 10, 2 -> 11, 3 -> 01.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   target       signed target position, latched on load
//   step_period  clk cycles between edges, latched on load (clamped)
//   load         one-cycle strobe: latch target/period, start or retarget
//   abort        one-cycle strobe: stop immediately, outputs hold
//   quadA/quadB  registered quadrature phases
//   position     signed count of emitted edges
//   busy         high while a move is in progress
//   done         one-cycle pulse when position reaches target
//   dbg_state    current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: load and abort are fire-and-forget strobes sampled on every
// rising edge; there is no ready. abort wins over a simultaneous load.
// -----------------------------------------------------------------------------
module quad_gen #(
   parameter int unsigned CLK_FREQ_HZ     = 32_000_000,
   parameter int unsigned MIN_STEP_PERIOD = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] target,
   input  logic        [15:0] step_period,
   input  logic               load,
   input  logic               abort,
   output logic               quadA,
   output logic               quadB,
   output logic signed [31:0] position,
   output logic               busy,
   output logic               done,
   output logic               dbg_state
);

   if (CLK_FREQ_HZ == 0 || MIN_STEP_PERIOD < 1 || MIN_STEP_PERIOD > 65535) begin : g_param_check
      $error("quad_gen: CLK_FREQ_HZ must be nonzero and MIN_STEP_PERIOD in 1..65535");
   end

   localparam logic [15:0] MIN_P = 16'(MIN_STEP_PERIOD);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state;
   logic        [15:0] cnt;
   logic        [15:0] per;
   logic signed [31:0] tgt;

   logic        [15:0] load_period;
   logic signed [31:0] diff;
   logic               edge_due;
   logic signed [31:0] pos_next;

   assign dbg_state   = state;
   assign load_period = (step_period < MIN_P) ? MIN_P : step_period;

   // Wrapping 32-bit subtraction: the sign bit picks the direction, so a
   // target just past 0x7FFFFFFF is reached by stepping forward through wrap.
   assign diff = tgt - position;

   // ">=" rather than "==" so a retarget to a shorter period whose count is
   // already past the new limit still fires on the next cycle instead of
   // waiting for the 16-bit counter to wrap.
   assign edge_due = (state == S_RUN) && (cnt >= (per - 16'd1));

   // Position as it will be after this cycle's edge (if any); a load in the
   // same cycle is compared against this post-edge value.
   assign pos_next = edge_due ? (diff[31] ? position - 32'sd1 : position + 32'sd1)
                              : position;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 16'd0;
         per      <= MIN_P;
         tgt      <= 32'sd0;
         position <= 32'sd0;
         quadA    <= 1'b0;
         quadB    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 16'd0;
         end else begin
            if (edge_due) begin
               position <= pos_next;
               // Gray mapping of position mod 4: only one phase flips per step.
               quadA    <= pos_next[1] ^ pos_next[0];
               quadB    <= pos_next[1];
               cnt      <= 16'd0;
            end else if (state == S_RUN) begin
               cnt <= cnt + 16'd1;
            end

            if (load) begin
               tgt <= target;
               per <= load_period;
               if (target == pos_next) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= 16'd0;
               end else if (state == S_IDLE) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  cnt   <= 16'd0;
               end
               // Retarget while running keeps the counter, so edge spacing
               // is measured from the previous edge.
            end else if (edge_due && (pos_next == tgt)) begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_gen
//   Self-checking bench for quad_gen. A time-based reference model (absolute
//   edge times, signed arithmetic) predicts position/phases/busy/done every
//   cycle; a scoreboard queue holds expected positions per edge; a small
//   behavioural quadrature decoder with a 5-stage input delay checks loopback.
// -----------------------------------------------------------------------------
module tb_quad_gen;

   localparam int MIN_P = 16;

   logic               clk;
   logic               reset;
   logic signed [31:0] target;
   logic        [15:0] step_period;
   logic               load;
   logic               abort;
   logic               quadA;
   logic               quadB;
   logic signed [31:0] position;
   logic               busy;
   logic               done;
   logic               dbg_state;

   int tests = 0;
   int fails = 0;

   quad_gen #(.CLK_FREQ_HZ(32_000_000), .MIN_STEP_PERIOD(MIN_P)) dut (
      .clk(clk), .reset(reset), .target(target), .step_period(step_period),
      .load(load), .abort(abort), .quadA(quadA), .quadB(quadB),
      .position(position), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   logic signed [31:0] m_pos, m_tgt, m_d;
   int                 m_per;
   logic               m_active, m_done;
   int                 cyc, ref_t, next_t;
   logic signed [31:0] exp_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pos = 0; m_tgt = 0; m_per = MIN_P; m_active = 0; m_done = 0;
         cyc = 0; ref_t = 0; next_t = 0;
         exp_q.delete();
      end else begin
         cyc++;
         m_done = 0;
         if (abort) begin
            m_active = 0;
         end else begin
            if (m_active && cyc >= next_t) begin
               m_d = m_tgt - m_pos;
               if (m_d > 0) m_pos = m_pos + 1; else m_pos = m_pos - 1;
               exp_q.push_back(m_pos);
               ref_t  = cyc;
               next_t = cyc + m_per;
               if (m_pos == m_tgt && !load) begin m_active = 0; m_done = 1; end
            end
            if (load) begin
               m_tgt = target;
               m_per = (int'(step_period) < MIN_P) ? MIN_P : int'(step_period);
               if (target == m_pos) begin
                  m_active = 0; m_done = 1;
               end else if (!m_active) begin
                  m_active = 1; ref_t = cyc; next_t = cyc + m_per;
               end else begin
                  next_t = ref_t + m_per;
               end
            end
         end
      end
   end

   function automatic logic [1:0] ab_of(input logic signed [31:0] p);
      case (p[1:0])
         2'd0:    return 2'b00;
         2'd1:    return 2'b10;
         2'd2:    return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic logic [35:0] exp_vec();
      return {m_pos, ab_of(m_pos), m_active, m_done};
   endfunction

   // ---------------- loopback decoder (5-stage input delay) ----------------
   logic [1:0] dl [5];
   logic [1:0] dprev;
   int         dec_count;

   function automatic int gidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 5; i++) dl[i] = 2'b00;
         dprev = 2'b00; dec_count = 0;
      end else begin
         if (dl[4] !== dprev) begin
            case ((gidx(dl[4]) - gidx(dprev)) & 3)
               1:       dec_count++;
               3:       dec_count--;
               default: ;
            endcase
            dprev = dl[4];
         end
         for (int i = 4; i > 0; i--) dl[i] = dl[i-1];
         dl[0] = {quadA, quadB};
      end
   end

   // ---------------- edge scoreboard / phase monitor ----------------
   logic               pa = 0, pb = 0, prev_rst = 1;
   logic signed [31:0] last_pos = 0;
   logic signed [31:0] e_pos;

   always @(negedge clk) begin
      if (!reset && !prev_rst) begin
         if (quadA !== pa || quadB !== pb) begin
            tests++;
            if (quadA !== pa && quadB !== pb) begin
               fails++;
               $display("FAIL two_phase_toggle: AB %b%b -> %b%b, required single-phase change", pa, pb, quadA, quadB);
            end
         end
         if (position !== last_pos) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL edge_scoreboard: unexpected position %0d, required no edge", position);
            end else begin
               e_pos = exp_q.pop_front();
               if (position !== e_pos) begin
                  fails++;
                  $display("FAIL edge_scoreboard: position %0d, required %0d", position, e_pos);
               end
            end
         end
      end
      pa = quadA; pb = quadB; last_pos = position; prev_rst = reset;
   end

   // ---------------- driver ----------------
   task automatic drive_load(input logic signed [31:0] t, input logic [15:0] sp);
      target = t; step_period = sp; load = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; load = 0; abort = 0; target = 0; step_period = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL reset_idle: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if ({position, quadA, quadB, busy, done, dbg_state} !== 37'd0) begin
         fails++; $display("FAIL reset_values: got %h, required 0", {position, quadA, quadB, busy, done, dbg_state});
      end
   endtask

   task automatic test_basic();
      drive_load(4, 20);
      for (int i = 0; i < 90; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL basic t=%0d: got %h, required %h", i + 1, {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (position !== 4 || {quadA, quadB} !== 2'b00 || busy !== 1'b0) begin
         fails++; $display("FAIL basic_final: pos=%0d ab=%b%b busy=%b, required 4 00 0", position, quadA, quadB, busy);
      end
      tests++;
      if (dec_count !== 4) begin fails++; $display("FAIL basic_decoder: count %0d, required 4", dec_count); end
   endtask

   task automatic test_clamp();
      drive_load(-2, 3);
      for (int i = 0; i < 6 * 16 + 10; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL clamp t=%0d: got %h, required %h", i + 1, {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (position !== -2 || {quadA, quadB} !== 2'b11) begin
         fails++; $display("FAIL clamp_final: pos=%0d ab=%b%b, required -2 11", position, quadA, quadB);
      end
      tests++;
      if (dec_count !== -2) begin fails++; $display("FAIL clamp_decoder: count %0d, required -2", dec_count); end
   endtask

   task automatic test_retarget();
      int hit = 0;
      drive_load(100, 16);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL retarget_run: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
         if (m_pos == 10) begin hit = 1; break; end
      end
      tests++;
      if (hit == 0) begin fails++; $display("FAIL retarget_reach: position %0d, required 10 within budget", position); end
      repeat ($urandom_range(0, 13)) @(negedge clk);
      drive_load(8, 16);
      for (int i = 0; i < 3 * 16 + 10; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL retarget_back: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (position !== 8 || busy !== 1'b0) begin
         fails++; $display("FAIL retarget_final: pos=%0d busy=%b, required 8 0", position, busy);
      end
   endtask

   task automatic test_abort();
      int hit = 0;
      drive_load(0, 16);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL abort_home: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      drive_load(50, 16);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL abort_run: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
         if (m_pos == 5) begin hit = 1; break; end
      end
      tests++;
      if (hit == 0) begin fails++; $display("FAIL abort_reach: position %0d, required 5 within budget", position); end
      repeat ($urandom_range(0, 12)) @(negedge clk);
      abort = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); abort = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL abort_hold: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if ({quadA, quadB} !== 2'b10 || position !== 5 || busy !== 1'b0) begin
         fails++; $display("FAIL abort_frozen: pos=%0d ab=%b%b busy=%b, required 5 10 0", position, quadA, quadB, busy);
      end
      drive_load(5, 16);
      @(negedge clk); load = 0;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || position !== 5) begin
         fails++; $display("FAIL abort_zero_move: done=%b busy=%b pos=%0d, required 1 0 5", done, busy, position);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL abort_after: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
   endtask

   task automatic test_wrap_dir();
      // Difference of exactly 0x80000000 is negative: reverse.
      drive_load(m_pos + 32'sh8000_0000, 16);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL wrap_rev: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (position !== 3) begin fails++; $display("FAIL wrap_rev_pos: pos=%0d, required 3", position); end
      abort = 1'b1;
      // Difference of 0x7FFFFFFF is positive: forward.
      @(negedge clk); abort = 0;
      drive_load(m_pos + 32'sh7FFF_FFFF, 20);
      for (int i = 0; i < 45; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL wrap_fwd: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (position !== 5) begin fails++; $display("FAIL wrap_fwd_pos: pos=%0d, required 5", position); end
      abort = 1'b1;
      @(negedge clk); abort = 0;
   endtask

   task automatic test_back_to_back();
      for (int v = 0; v < 2; v++) begin
         int hit = 0;
         logic signed [31:0] fin;
         drive_load(m_pos + 2, 16);
         for (int i = 0; i < 200; i++) begin
            @(negedge clk); load = 0;
            tests++;
            if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
               fails++; $display("FAIL b2b_run: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
            end
            if (m_active && m_pos == m_tgt - 1 && cyc == next_t - 1) begin hit = 1; break; end
         end
         tests++;
         if (hit == 0) begin fails++; $display("FAIL b2b_reach: final edge not reached, pos=%0d", position); end
         fin = m_pos + 1;
         // Load coinciding with the final edge: same target -> stop, else continue.
         drive_load((v == 0) ? fin : fin + 3, 16);
         for (int i = 0; i < 70; i++) begin
            @(negedge clk); load = 0;
            tests++;
            if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
               fails++; $display("FAIL b2b_load v=%0d: got %h, required %h", v, {position, quadA, quadB, busy, done}, exp_vec());
            end
         end
         tests++;
         if (position !== ((v == 0) ? fin : fin + 3)) begin
            fails++; $display("FAIL b2b_final v=%0d: pos=%0d, required %0d", v, position, (v == 0) ? fin : fin + 3);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 14; k++) begin
         int n;
         drive_load(m_pos + $signed($urandom_range(0, 30)) - 15, 16'($urandom_range(0, 40)));
         n = $urandom_range(5, 400);
         for (int i = 0; i < n; i++) begin
            @(negedge clk); load = 0; abort = 0;
            tests++;
            if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
               fails++; $display("FAIL random k=%0d: got %h, required %h", k, {position, quadA, quadB, busy, done}, exp_vec());
            end
            if (i == n - 1 && $urandom_range(0, 4) == 0) abort = 1'b1;
         end
         @(negedge clk); abort = 0;
      end
      drive_load(m_pos - 3, 16);
      for (int i = 0; i < 2000 && (m_active || i < 10); i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL random_settle: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      repeat (8) @(negedge clk);
      tests++;
      if (dec_count !== m_pos) begin fails++; $display("FAIL random_decoder: count %0d, required %0d", dec_count, m_pos); end
   endtask

   task automatic test_reset_mid();
      drive_load(m_pos + 10, 16);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); load = 0;
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL reset_mid_run: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      #1 reset = 1'b1;
      #1;
      tests++;
      if ({position, quadA, quadB, busy, done} !== 36'd0) begin
         fails++; $display("FAIL reset_mid_async: got %h, required 0", {position, quadA, quadB, busy, done});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests++;
         if ({position, quadA, quadB, busy, done} !== exp_vec()) begin
            fails++; $display("FAIL reset_mid_idle: got %h, required %h", {position, quadA, quadB, busy, done}, exp_vec());
         end
      end
      tests++;
      if (dec_count !== 0) begin fails++; $display("FAIL reset_mid_decoder: count %0d, required 0", dec_count); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      reset = 1'b1; load = 0; abort = 0; target = 0; step_period = 0;
      test_reset();
      test_basic();
      test_clamp();
      test_retarget();
      test_abort();
      test_wrap_dir();
      test_back_to_back();
      test_random();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL edge_queue_empty: %0d edges never seen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
